// File: rtl/hwpe_stream_sink_sched_pkg.sv
// Types shared by the sink job scheduler: sink control/flag structs, job descriptor, FSM states.
// job_to_ctrl() expands a descriptor into a full address-generator control word.
package hwpe_stream_sink_sched_pkg;

  localparam int SINK_TRANS_CNT = 16;

  typedef struct packed {
    logic [31:0]               base_addr;
    logic [SINK_TRANS_CNT-1:0] trans_size;
    logic [15:0]               line_stride;
    logic [15:0]               line_length;
    logic [15:0]               feat_stride;
    logic [15:0]               feat_length;
    logic [15:0]               feat_roll;
    logic                      loop_outer;
    logic                      realign_type;
  } addressgen_ctrl_t;

  typedef struct packed {
    logic             req_start;
    addressgen_ctrl_t addressgen_ctrl;
  } ctrl_sourcesink_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } flags_sourcesink_t;

  typedef struct packed {
    logic [31:0]               base_addr;
    logic [SINK_TRANS_CNT-1:0] trans_size;
    logic [15:0]               line_stride;
    logic [15:0]               line_length;
  } sink_job_t;

  typedef enum logic [1:0] {SCHED_IDLE, SCHED_START, SCHED_WAIT} sched_state_t;

  // Jobs are single-feature 2D transfers: one feature of length 1, no outer loop.
  function automatic addressgen_ctrl_t job_to_ctrl(input sink_job_t j);
    addressgen_ctrl_t c;
    c             = '0;
    c.base_addr   = j.base_addr;
    c.trans_size  = j.trans_size;
    c.line_stride = j.line_stride;
    c.line_length = j.line_length;
    c.feat_length = 16'd1;
    return c;
  endfunction

endpackage

// File: rtl/hwpe_stream_sink_job_fifo.sv
// Flip-flop FIFO of {id, descriptor} entries; pop data is the combinational head entry.
// One-cycle push-to-pop latency; a push while full is dropped, so the writer must gate on full.
module hwpe_stream_sink_job_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Extra wrap bit distinguishes full from empty when the indices coincide.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/hwpe_stream_sink_sched.sv
// Round-robin job scheduler sharing one hwpe_stream_sink among NB_REQ requesters; accept->req_start 2 cycles.
// Requesters are back-pressured while the job FIFO is full; the sink shares clear_i and rst_i with this block.
// HWPE_SINK_SCHED_PERF_EN adds a saturating per-job cycle counter on cycles_o.
module hwpe_stream_sink_sched
  import hwpe_stream_sink_sched_pkg::*;
#(
  parameter int NB_REQ         = 2,
  parameter int JOB_FIFO_DEPTH = 4,
  parameter int TRANS_CNT      = SINK_TRANS_CNT,
  parameter int ID_W           = $clog2(NB_REQ)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic [NB_REQ-1:0] job_valid_i,
  output logic [NB_REQ-1:0] job_ready_o,
  input  sink_job_t         job_i [NB_REQ],
  output ctrl_sourcesink_t  ctrl_o,
  input  flags_sourcesink_t flags_i,
  output logic              done_o,
  output logic [ID_W-1:0]   done_id_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [31:0]       cycles_o
);

  typedef struct packed {
    logic [ID_W-1:0] id;
    sink_job_t       job;
  } entry_t;

  entry_t           push_ent, pop_ent;
  logic             fifo_full, fifo_empty, push, pop, pop_zero;
  logic [ID_W-1:0]  rr_ptr, gnt_idx;
  logic             gnt_any;
  sched_state_t     state;
  addressgen_ctrl_t ag_q;
  logic [ID_W-1:0]  cur_id, done_id_q;
  logic             done_q, err_q;

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NB_REQ) s = s - NB_REQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    gnt_any     = 1'b0;
    gnt_idx     = rr_ptr;
    job_ready_o = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      if (!gnt_any && job_valid_i[rr_idx(rr_ptr, k)]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx(rr_ptr, k);
      end
    end
    if (gnt_any && !fifo_full) job_ready_o[gnt_idx] = 1'b1;
  end

  assign push         = gnt_any && !fifo_full;
  assign push_ent.id  = gnt_idx;
  assign push_ent.job = job_i[gnt_idx];
  assign pop          = (state == SCHED_IDLE) && !fifo_empty;
  assign pop_zero     = (pop_ent.job.trans_size == TRANS_CNT'(0));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        rr_ptr <= '0;
    else if (clear_i) rr_ptr <= '0;
    else if (push)    rr_ptr <= rr_idx(gnt_idx, 1);
  end

  hwpe_stream_sink_job_fifo #(
    .DEPTH (JOB_FIFO_DEPTH),
    .DW    ($bits(entry_t))
  ) i_job_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (clear_i),
    .push      (push),
    .push_data (push_ent),
    .pop       (pop),
    .pop_data  (pop_ent),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= SCHED_IDLE;
      ag_q      <= '0;
      cur_id    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      done_id_q <= '0;
    end else if (clear_i) begin
      state     <= SCHED_IDLE;
      ag_q      <= '0;
      cur_id    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      done_id_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        SCHED_IDLE: begin
          if (pop) begin
            ag_q   <= job_to_ctrl(pop_ent.job);
            cur_id <= pop_ent.id;
            // Zero-length jobs never reach the sink: reject them straight from IDLE.
            if (pop_zero) begin
              done_q    <= 1'b1;
              err_q     <= 1'b1;
              done_id_q <= pop_ent.id;
            end else begin
              state <= SCHED_START;
            end
          end
        end
        SCHED_START: if (flags_i.ready_start) state <= SCHED_WAIT;
        SCHED_WAIT: begin
          if (flags_i.done) begin
            done_q    <= 1'b1;
            done_id_q <= cur_id;
            state     <= SCHED_IDLE;
          end
        end
        default: state <= SCHED_IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl_o                 = '0;
    ctrl_o.req_start       = (state == SCHED_START);
    ctrl_o.addressgen_ctrl = ag_q;
  end

  assign done_o    = done_q;
  assign err_o     = err_q;
  assign done_id_o = done_id_q;
  assign busy_o    = !fifo_empty || (state != SCHED_IDLE);

`ifdef HWPE_SINK_SCHED_PERF_EN
  logic [31:0] cnt_q, cycles_q;

  // cycles_o counts the completing cycle too, so it equals the cycles spent in START plus WAIT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      cycles_q <= '0;
    end else if (clear_i) begin
      cnt_q    <= '0;
      cycles_q <= '0;
    end else begin
      if (pop && !pop_zero)
        cnt_q <= '0;
      else if (state != SCHED_IDLE && cnt_q != 32'hFFFF_FFFF)
        cnt_q <= cnt_q + 32'd1;
      if (state == SCHED_WAIT && flags_i.done)
        cycles_q <= (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
      else if (pop && pop_zero)
        cycles_q <= '0;
    end
  end

  assign cycles_o = cycles_q;
`else
  assign cycles_o = '0;
`endif

endmodule

// File: tb/tb_hwpe_stream_sink_sched.sv
// Directed + randomized bench for hwpe_stream_sink_sched against a queue-based reference model.
module tb_hwpe_stream_sink_sched;
  import hwpe_stream_sink_sched_pkg::*;

  localparam int NB_REQ = 2;
  localparam int DEPTH  = 4;
  localparam int ID_W   = 1;
  localparam int PH_IDLE = 0, PH_START = 1, PH_WAIT = 2;

  logic              clk = 1'b0;
  logic              rst, clear;
  logic [NB_REQ-1:0] job_valid, job_ready;
  sink_job_t         job [NB_REQ];
  ctrl_sourcesink_t  ctrl;
  flags_sourcesink_t flags;
  logic              done, err, busy;
  logic [ID_W-1:0]   done_id;
  logic [31:0]       cycles;
  logic              sk_rs, sk_done;

  always #5 clk = ~clk;

  assign flags.ready_start = sk_rs;
  assign flags.done        = sk_done;

  hwpe_stream_sink_sched #(.NB_REQ(NB_REQ), .JOB_FIFO_DEPTH(DEPTH), .TRANS_CNT(16), .ID_W(ID_W)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .job_valid_i(job_valid), .job_ready_o(job_ready), .job_i(job),
    .ctrl_o(ctrl), .flags_i(flags),
    .done_o(done), .done_id_o(done_id), .err_o(err), .busy_o(busy), .cycles_o(cycles)
  );

  int n_assert = 0, n_fail = 0, cyc_n = 0;

  // Reference model: pending jobs as a queue, service phase as a plain integer.
  typedef struct { int id; sink_job_t job; } ent_t;
  ent_t q[$];
  int m_rr, m_phase, m_cnt, m_id, m_done_id, m_cycles;
  bit m_done, m_err;
  addressgen_ctrl_t m_ag;

  // Sink emulation knobs.
  int rs_delay = 0, done_delay = 0, st_cnt = 0, wt_cnt = 0;
  bit stray_en = 0, rand_mode = 0;
  int df_q[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic addressgen_ctrl_t bench_map(input sink_job_t j);
    addressgen_ctrl_t c;
    c = '0;
    c.base_addr = j.base_addr; c.trans_size = j.trans_size;
    c.line_stride = j.line_stride; c.line_length = j.line_length;
    c.feat_length = 16'd1;
    return c;
  endfunction

  function automatic sink_job_t rand_job(input bit allow_zero);
    sink_job_t j;
    j.base_addr   = $urandom;
    j.trans_size  = 16'($urandom_range(1, 500));
    j.line_stride = 16'($urandom);
    j.line_length = 16'($urandom);
    if (allow_zero && $urandom_range(0, 5) == 0) j.trans_size = '0;
    return j;
  endfunction

  function automatic int model_grant();
    if (q.size() >= DEPTH) return -1;
    for (int k = 0; k < NB_REQ; k++)
      if (job_valid[(m_rr + k) % NB_REQ]) return (m_rr + k) % NB_REQ;
    return -1;
  endfunction

  function automatic logic [NB_REQ-1:0] exp_ready();
    logic [NB_REQ-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] exp_cycles(input int v);
`ifdef HWPE_SINK_SCHED_PERF_EN
    return 32'(v);
`else
    return 32'(v) & 32'h0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_rr = 0; m_phase = PH_IDLE; m_cnt = 0; m_id = 0; m_done_id = 0; m_cycles = 0;
    m_done = 0; m_err = 0; m_ag = '0;
  endtask

  task automatic model_advance();
    int g;
    ent_t e;
    if (clear) begin model_reset(); return; end
    g = model_grant();
    m_done = 0; m_err = 0;
    case (m_phase)
      PH_IDLE: if (q.size() > 0) begin
        e = q.pop_front();
        m_ag = bench_map(e.job);
        m_id = e.id;
        if (e.job.trans_size == 0) begin
          m_done = 1; m_err = 1; m_done_id = e.id; m_cycles = 0;
        end else begin
          m_phase = PH_START; m_cnt = 0;
        end
      end
      PH_START: begin m_cnt++; if (sk_rs) m_phase = PH_WAIT; end
      default: begin
        m_cnt++;
        if (sk_done) begin m_done = 1; m_done_id = m_id; m_cycles = m_cnt; m_phase = PH_IDLE; end
      end
    endcase
    if (g >= 0) begin
      e.id = g; e.job = job[g];
      q.push_back(e);
      m_rr = (g + 1) % NB_REQ;
    end
  endtask

  task automatic sink_drive();
    if (m_phase == PH_START) begin
      sk_rs = (st_cnt >= rs_delay); st_cnt++; wt_cnt = 0; sk_done = 0;
    end else if (m_phase == PH_WAIT) begin
      sk_rs = 0; sk_done = (wt_cnt == done_delay); wt_cnt++; st_cnt = 0;
      if (sk_done) df_q.push_back(cyc_n);
    end else begin
      st_cnt = 0; wt_cnt = 0;
      sk_rs = 1'($urandom_range(0, 1));
      sk_done = stray_en && ($urandom_range(0, 3) == 0);
      if (rand_mode) begin rs_delay = $urandom_range(0, 3); done_delay = $urandom_range(0, 5); end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_advance();
    cyc_n++;
    #1;
    sink_drive();
  endtask

  task automatic chk();
    #1;
    check("ready", job_ready, exp_ready());
    check("req_start", ctrl.req_start, m_phase == PH_START);
    check("addrgen", ctrl.addressgen_ctrl, m_ag);
    check("done", done, m_done);
    check("busy", busy, (q.size() > 0) || (m_phase != PH_IDLE));
    if (m_done) begin
      check("done_id", done_id, m_done_id);
      check("err", err, m_err);
      check("cycles", cycles, exp_cycles(m_cycles));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, got, n_rs, n_fall, prev;
    int gq[$], dq[$], rise[$];
    sink_job_t j;

    rst = 1; clear = 0; job_valid = '0; sk_rs = 0; sk_done = 0;
    job[0] = '0; job[1] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", job_ready, 2'b00);
    check("rst_ctrl", ctrl, '0);
    check("rst_done", done, 1'b0);
    check("rst_done_id", done_id, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cycles", cycles, 32'd0);
    rst = 0;

    // Single job from requester 0.
    rs_delay = 0; done_delay = 9;
    j = '0; j.base_addr = 32'h100; j.trans_size = 16'd8; j.line_stride = 16'd4; j.line_length = 16'd8;
    cyc(); job[0] = j; job_valid = 2'b01; chk();
    t = cyc_n;
    check("single_grant", job_ready, 2'b01);
    cyc(); job_valid = '0; chk();
    check("single_no_start_t1", ctrl.req_start, 1'b0);
    cyc(); chk();
    check("single_start_t2", ctrl.req_start, 1'b1);
    check("single_base", ctrl.addressgen_ctrl.base_addr, 32'h100);
    check("single_size", ctrl.addressgen_ctrl.trans_size, 16'd8);
    check("single_stride", ctrl.addressgen_ctrl.line_stride, 16'd4);
    check("single_len", ctrl.addressgen_ctrl.line_length, 16'd8);
    check("single_feat_len", ctrl.addressgen_ctrl.feat_length, 16'd1);
    got = 0;
    for (int i = 0; i < 30 && got == 0; i++) begin cyc(); chk(); if (done) got = 1; end
    check("single_done_lat", cyc_n - t, 13);
    check("single_done_id", done_id, 1'b0);
    check("single_err", err, 1'b0);
    check("single_cycles", cycles, exp_cycles(11));

    // Clear while idle returns the round-robin pointer to 0.
    cyc(); clear = 1; chk();
    cyc(); clear = 0; chk();

    // Round-robin fill with the sink refusing to start.
    rs_delay = 100; done_delay = 2;
    cyc(); job_valid = 2'b11; job[0] = rand_job(0); job[1] = rand_job(0); chk();
    for (int i = 0; i < 8; i++) begin
      if (job_ready == 2'b01) gq.push_back(0);
      else if (job_ready == 2'b10) gq.push_back(1);
      cyc(); job[0] = rand_job(0); job[1] = rand_job(0); chk();
    end
    check("rr_grant_count", gq.size(), 5);
    foreach (gq[i]) check("rr_grant_order", gq[i], i % 2);
    check("rr_full_ready", job_ready, 2'b00);
    job_valid = '0; rs_delay = 0;
    for (int i = 0; i < 200 && dq.size() < 5; i++) begin
      cyc(); chk();
      if (done) dq.push_back(int'(done_id));
    end
    check("rr_done_count", dq.size(), 5);
    foreach (dq[i]) check("rr_done_order", dq[i], i % 2);

    // Backpressure: ready_start low for 5 START cycles.
    rs_delay = 5; done_delay = 1;
    cyc(); job_valid = 2'b10; job[1] = rand_job(0); chk();
    cyc(); job_valid = '0; chk();
    n_rs = 0; n_fall = 0; prev = 0; got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      cyc(); chk();
      if (ctrl.req_start) n_rs++;
      if (prev == 1 && !ctrl.req_start) n_fall++;
      prev = int'(ctrl.req_start);
      if (done) got = 1;
    end
    check("bp_req_cycles", n_rs, 6);
    check("bp_transitions", n_fall, 1);
    check("bp_done_seen", got, 1);

    // Zero-length job is rejected without starting the sink.
    rs_delay = 0;
    j = rand_job(0); j.trans_size = '0;
    cyc(); job_valid = 2'b01; job[0] = j; chk();
    cyc(); job_valid = '0; chk();
    n_rs = int'(ctrl.req_start);
    cyc(); chk();
    check("zero_done", done, 1'b1);
    check("zero_err", err, 1'b1);
    check("zero_id", done_id, 1'b0);
    check("zero_cycles", cycles, 32'd0);
    for (int i = 0; i < 4; i++) begin cyc(); chk(); n_rs += int'(ctrl.req_start); end
    check("zero_no_start", n_rs, 0);

    // Back-to-back: next req_start exactly 2 cycles after the sink's done.
    rs_delay = 0; done_delay = 3; df_q.delete(); prev = 0;
    cyc(); job_valid = 2'b11; job[0] = rand_job(0); job[1] = rand_job(0); chk();
    cyc(); job_valid = 2'b01; job[0] = rand_job(0); chk();
    cyc(); job_valid = '0; chk();
    for (int i = 0; i < 60 && rise.size() < 2; i++) begin
      if (ctrl.req_start && prev == 0) rise.push_back(cyc_n);
      prev = int'(ctrl.req_start);
      cyc(); chk();
    end
    if (ctrl.req_start && prev == 0) rise.push_back(cyc_n);
    check("b2b_rises", rise.size(), 2);
    check("b2b_gap", (rise.size() == 2 && df_q.size() > 0) ? rise[1] - df_q[0] : -1, 2);
    for (int i = 0; i < 20; i++) begin cyc(); chk(); end

    // Clear while waiting on the sink with three jobs queued.
    rs_delay = 0; done_delay = 50;
    for (int i = 0; i < 4; i++) begin
      cyc(); job_valid = 2'b11; job[0] = rand_job(0); job[1] = rand_job(0); chk();
    end
    cyc(); job_valid = '0; clear = 1; chk();
    check("clr_pre_wait", (m_phase == PH_WAIT) && (q.size() == 3) && busy, 1'b1);
    cyc(); clear = 0; chk();
    check("clr_busy", busy, 1'b0);
    check("clr_ctrl", ctrl, '0);
    check("clr_done", done, 1'b0);
    stray_en = 1; got = 0;
    for (int i = 0; i < 12; i++) begin cyc(); chk(); if (done || busy) got = 1; end
    check("clr_stray_ignored", got, 0);

    // Randomized traffic with occasional clears and rejected jobs.
    rand_mode = 1;
    for (int i = 0; i < 500; i++) begin
      cyc();
      job_valid = 2'($urandom_range(0, 3));
      job[0] = rand_job(1); job[1] = rand_job(1);
      clear = ($urandom_range(0, 99) == 0);
      chk();
    end
    job_valid = '0; clear = 0;
    for (int i = 0; i < 80; i++) begin cyc(); chk(); end
    check("drain_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
